// File: rtl/debug_poke.sv
// Debugger poke path: composes a 32-bit value from keyed hex nibbles and
// commits it to a register or data-memory word while the core is halted.

// Per-key conditioning: synchronizer, debouncer and rising-edge pulse.
module debug_poke_key #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key,
  output logic pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, acc, accD;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // Accepted level follows the synchronized level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (s2 != acc) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        acc <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulse on a rising edge of the accepted level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      accD  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      accD  <= acc;
      pulse <= acc & ~accD;
    end
  end
endmodule

module debug_poke #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [9:0]  switches,
  input  logic        keyEnter,
  input  logic        keyCommit,
  input  logic        keyClear,
  input  logic        halted,
  input  logic        wrAck,
  output logic        regWrEn,
  output logic [4:0]  regWrAddr,
  output logic        memWrEn,
  output logic [31:0] memWrAddr,
  output logic [31:0] wrData,
  output logic [31:0] entryData,
  output logic [3:0]  nibbleCount,
  output logic        busy,
  output logic        error
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, stateN;
  logic          entP, comP, clrP;
  logic [TW-1:0] toCnt, toN;
  logic          regEnN, memEnN, errN;
  logic [4:0]    regAddrN;
  logic [31:0]   memAddrN, wrDataN, entryN;
  logic [3:0]    cntN;

  debug_poke_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .Clk(Clk), .Rst(Rst), .key(keyEnter), .pulse(entP));
  debug_poke_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .Clk(Clk), .Rst(Rst), .key(keyCommit), .pulse(comP));
  debug_poke_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .Clk(Clk), .Rst(Rst), .key(keyClear), .pulse(clrP));

  assign busy = (state == REQ);

  // State and all registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      toCnt       <= '0;
      regWrEn     <= 1'b0;
      memWrEn     <= 1'b0;
      regWrAddr   <= '0;
      memWrAddr   <= '0;
      wrData      <= '0;
      entryData   <= '0;
      nibbleCount <= '0;
      error       <= 1'b0;
    end else begin
      state       <= stateN;
      toCnt       <= toN;
      regWrEn     <= regEnN;
      memWrEn     <= memEnN;
      regWrAddr   <= regAddrN;
      memWrAddr   <= memAddrN;
      wrData      <= wrDataN;
      entryData   <= entryN;
      nibbleCount <= cntN;
      error       <= errN;
    end
  end

  // Next-state logic; clear beats commit beats enter, and keys are ignored in REQ.
  always_comb begin
    stateN   = state;
    toN      = toCnt;
    regEnN   = regWrEn;
    memEnN   = memWrEn;
    regAddrN = regWrAddr;
    memAddrN = memWrAddr;
    wrDataN  = wrData;
    entryN   = entryData;
    cntN     = nibbleCount;
    errN     = error;
    case (state)
      IDLE: begin
        if (clrP) begin
          entryN = '0;
          cntN   = '0;
          errN   = 1'b0;
        end else if (comP) begin
          if (!halted || (!switches[9] && switches[4:0] == 5'd0)) begin
            errN = 1'b1;
          end else begin
            stateN   = REQ;
            toN      = '0;
            wrDataN  = entryData;
            regAddrN = switches[4:0];
            memAddrN = {23'b0, switches[8:0]};
            regEnN   = ~switches[9];
            memEnN   = switches[9];
          end
        end else if (entP) begin
          entryN = {entryData[27:0], switches[3:0]};
          if (nibbleCount != 4'd8) cntN = nibbleCount + 4'd1;
        end
      end
      REQ: begin
        // Ack takes precedence over a simultaneous halt drop.
        if (wrAck) begin
          stateN = IDLE;
          regEnN = 1'b0;
          memEnN = 1'b0;
          cntN   = '0;
          errN   = 1'b0;
        end else if (!halted || toCnt == TW'(ACK_TIMEOUT)) begin
          stateN = IDLE;
          regEnN = 1'b0;
          memEnN = 1'b0;
          errN   = 1'b1;
        end else begin
          toN = toCnt + TW'(1);
        end
      end
      default: stateN = IDLE;
    endcase
  end
endmodule
